// File: rtl/sap_ctrl_pkg.sv
// SAP-U control sequencer shared definitions: control bit indices,
// opcodes and FSM state encoding.
package sap_ctrl_pkg;

  localparam int CTRL_HLT = 15;
  localparam int CTRL_MI  = 14;
  localparam int CTRL_RI  = 13;
  localparam int CTRL_RO  = 12;
  localparam int CTRL_IO  = 11;
  localparam int CTRL_II  = 10;
  localparam int CTRL_AI  = 9;
  localparam int CTRL_AO  = 8;
  localparam int CTRL_EO  = 7;
  localparam int CTRL_SU  = 6;
  localparam int CTRL_BI  = 5;
  localparam int CTRL_OI  = 4;
  localparam int CTRL_CE  = 3;
  localparam int CTRL_CO  = 2;
  localparam int CTRL_J   = 1;
  localparam int CTRL_FI  = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/sap_step_counter.sv
// Micro-step counter: async reset, enable, sync clear (wins over
// enable), wraps from NUM_STEPS-1 back to 0.
module sap_step_counter #(
  parameter int NUM_STEPS = 5,
  parameter int STEP_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  output logic [STEP_W-1:0] count
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);

  logic [STEP_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == LAST) count_d = '0;
      else count_d = count_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-U microcode sequencer: IDLE/RUN/HALTED FSM plus microcode ROM.
// Define SAP_EARLY_STEP_RESET_EN to end an instruction on its first zero step.
module sap_control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 5,
  parameter int STEP_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [15:0]       ctrl,
  output logic [STEP_W-1:0] step,
  output logic              halted
);

  state_e state_q, state_d;
  logic   halted_q, halted_d;

  logic [STEP_W-1:0] step_w;
  logic [15:0]       fetch_w;
  logic [15:0]       exec_w;
  logic              is_t0, is_t1, is_t2, is_t3, is_t4;
  logic              in_run, hlt_w, cnt_en, cnt_clr;

  assign is_t0 = (step_w == STEP_W'(0));
  assign is_t1 = (step_w == STEP_W'(1));
  assign is_t2 = (step_w == STEP_W'(2));
  assign is_t3 = (step_w == STEP_W'(3));
  assign is_t4 = (step_w == STEP_W'(4));

  always_comb begin
    fetch_w = '0;
    if (is_t0) begin
      fetch_w[CTRL_CO] = 1'b1;
      fetch_w[CTRL_MI] = 1'b1;
    end
    if (is_t1) begin
      fetch_w[CTRL_RO] = 1'b1;
      fetch_w[CTRL_II] = 1'b1;
      fetch_w[CTRL_CE] = 1'b1;
    end
  end

  // Execute ROM; everything not listed here, including T5+, is zero
  always_comb begin
    exec_w = '0;
    case (opcode)
      OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
        if (is_t2) begin
          exec_w[CTRL_IO] = 1'b1;
          exec_w[CTRL_MI] = 1'b1;
        end
        if (is_t3) begin
          exec_w[CTRL_RO] = (opcode != OP_STA);
          exec_w[CTRL_AI] = (opcode == OP_LDA);
          exec_w[CTRL_BI] = (opcode == OP_ADD) ||
                            (opcode == OP_SUB);
          exec_w[CTRL_AO] = (opcode == OP_STA);
          exec_w[CTRL_RI] = (opcode == OP_STA);
        end
        if (is_t4 && (opcode == OP_ADD ||
                      opcode == OP_SUB)) begin
          exec_w[CTRL_EO] = 1'b1;
          exec_w[CTRL_AI] = 1'b1;
          exec_w[CTRL_FI] = 1'b1;
          exec_w[CTRL_SU] = (opcode == OP_SUB);
        end
      end
      OP_LDI: begin
        if (is_t2) begin
          exec_w[CTRL_IO] = 1'b1;
          exec_w[CTRL_AI] = 1'b1;
        end
      end
      OP_JMP, OP_JC, OP_JZ: begin
        if (is_t2 &&
            (opcode == OP_JMP ||
             (opcode == OP_JC && flag_c) ||
             (opcode == OP_JZ && flag_z))) begin
          exec_w[CTRL_IO] = 1'b1;
          exec_w[CTRL_J]  = 1'b1;
        end
      end
      OP_OUT: begin
        if (is_t2) begin
          exec_w[CTRL_AO] = 1'b1;
          exec_w[CTRL_OI] = 1'b1;
        end
      end
      OP_HLT: begin
        if (is_t2) exec_w[CTRL_HLT] = 1'b1;
      end
      default: exec_w = '0;
    endcase
  end

  assign in_run = (state_q == ST_RUN);
  assign ctrl   = in_run ? (fetch_w | exec_w) : '0;
  assign hlt_w  = ctrl[CTRL_HLT];
  assign cnt_en = in_run && !hlt_w;

`ifdef SAP_EARLY_STEP_RESET_EN
  assign cnt_clr = in_run && !is_t0 && !is_t1 &&
                   (exec_w == '0);
`else
  assign cnt_clr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (run) state_d = ST_RUN;
      ST_RUN:    if (hlt_w) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  sap_step_counter #(
    .NUM_STEPS (NUM_STEPS),
    .STEP_W    (STEP_W)
  ) u_step (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (step_w)
  );

  assign step   = step_w;
  assign halted = halted_q;

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Microcode sequencer for the SAP-U CPU.
- Steps through T-states: fetch, then execute.
- Decodes the 4-bit opcode held in the instruction register.
- Drives one 16-bit control word that gates every register load/output and the ALU onto the shared bus.
- Sits between the IR/flags flip-flops and every bus-attached register; it is the only source of their enables.

Parameters:
- NUM_STEPS, 5, micro-steps per instruction (T0..T4); legal range 5..8.
- STEP_W, 3, width of the step counter; must satisfy 2**STEP_W >= NUM_STEPS.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- run  input  1  start pulse; sampled only in IDLE.
- opcode  input  4  upper nibble of the IR.
- flag_c  input  1  registered carry flag.
- flag_z  input  1  registered zero flag.
- ctrl  output  16  control word, combinational from state/step/opcode/flags.
- step  output  STEP_W  current micro-step, registered.
- halted  output  1  high while in HALTED, registered.

Behaviour:
- ctrl bit map, 15..0: HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI.
- States and transitions:
  - IDLE -> RUN when run=1.
  - RUN -> HALTED at the edge after a step with ctrl[HLT]=1.
  - HALTED is exited only by reset.
- Reset: state=IDLE, step=0, halted=0, ctrl=0.
- ctrl is 0 in IDLE and in HALTED, regardless of opcode and flags.
- Fetch, all opcodes:
  - T0 = CO|MI.
  - T1 = RO|II|CE.
- Execute, T2..T4; unlisted steps = 0:
  - NOP(0x0): all 0.
  - LDA(0x1): T2 IO|MI; T3 RO|AI.
  - ADD(0x2): T2 IO|MI; T3 RO|BI; T4 EO|AI|FI.
  - SUB(0x3): as ADD, with T4 = EO|AI|SU|FI.
  - STA(0x4): T2 IO|MI; T3 AO|RI.
  - LDI(0x5): T2 IO|AI.
  - JMP(0x6): T2 IO|J.
  - JC(0x7): T2 IO|J if flag_c=1, else 0.
  - JZ(0x8): T2 IO|J if flag_z=1, else 0.
  - OUT(0xE): T2 AO|OI.
  - HLT(0xF): T2 HLT.
  - 0x9–0xD: treated as NOP.
- Step counter, in RUN:
  - Increments each clk.
  - Wraps NUM_STEPS-1 -> 0.
  - Steps T5..T(NUM_STEPS-1) output 0.
- Flags are evaluated combinationally in T2; the value present in that cycle decides the jump.
- On HLT: step freezes at 2 and halted=1 from the following edge.
- Opcode is assumed stable from T2 to the end of the instruction; a change mid-instruction alters ctrl immediately; no latching.
- Reset mid-instruction: immediate return to IDLE/step 0; the partial instruction is abandoned.
- run held high in RUN or HALTED: ignored.
- Latency: run sampled at edge N gives ctrl=CO|MI during cycle N+1.

Optional Feature:
- Macro: SAP_EARLY_STEP_RESET_EN.
- Defined:
  - In RUN, if step>=2 and the execute microcode for (opcode, step, flags) is all-zero, step returns to 0 at the next edge.
  - The zero step still appears for one cycle.
  - Example: LDI takes T0,T1,T2,T3(zero) then T0; NOP takes 3 cycles.
- Undefined: every instruction takes exactly NUM_STEPS cycles.

Decomposition:
- Package sap_ctrl_pkg holds:
  - Control bit index constants (CTRL_HLT..CTRL_FI).
  - Opcode localparams (OP_NOP..OP_HLT).
  - State encoding (ST_IDLE, ST_RUN, ST_HALTED).
- Sub-module sap_step_counter: STEP_W counter with async reset, enable, sync clear, and wrap at NUM_STEPS.
- The sequencer keeps the FSM and the combinational microcode ROM.

Test Plan:
- Reset, then run=1 for one cycle:
  - Next cycle: ctrl=0x4004 (MI|CO), step=0.
  - Following cycle: ctrl=0x1408 (RO|II|CE), step=1.
- opcode=0x2 (ADD), through T2..T4:
  - T2 = 0x4800.
  - T3 = 0x1020.
  - T4 = 0x0281.
  - Then step wraps to 0.
- opcode=0x7 (JC), T2:
  - flag_c=1 -> ctrl=0x0802.
  - flag_c=0 -> ctrl=0x0000.
  - Repeat for JZ with flag_z.
- opcode=0xF (HLT):
  - T2 ctrl=0x8000.
  - From the next edge: halted=1, ctrl=0, step stays 2.
  - run pulses ignored.
  - Reset returns to IDLE.
- Assert reset at T3 of a LDA: outputs clear to 0 asynchronously, before the next clk edge; run restarts at T0.
- With SAP_EARLY_STEP_RESET_EN: LDI sequence is step 0,1,2,3,0. Without it: 0,1,2,3,4,0.
